systolic_feeder: RTL and testbench

Transmit-side driver for the `systolic` matrix-multiply array. It accepts two full SIZE×SIZE operand matrices through a valid/ready handshake. It then streams them into the array as diagonally skewed row and column vectors, drives the array's `load_en`/`mult_en`/`acc_en`, and runs the drain beats. On completion it presents the array's `out` matrix as a result with a one-cycle `done` pulse. It replaces hand-built skewed stimulus and sits directly between the job source and the `systolic` instance.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_skew_mux.sv | 35 +++
 rtl/systolic_feeder.sv | 195 +++++++++++++++++++
 tb/tb_systolic_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: FSM state encoding,
// default element widths and the beat-counter width helper.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_t;

  localparam int DEF_IN_WIDTH  = 8;
  localparam int DEF_OUT_WIDTH = 32;

  // Beat index covers 0 .. 3*SIZE-3 (feed plus drain), so 3*SIZE states suffice.
  function automatic int beat_cnt_w(input int size);
    return $clog2(3 * size);
  endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// Diagonal skew selector: for beat t, row stream i carries A[i][t-i] and
// column stream j carries B[t-j][j]; positions outside the matrix are zero.
module systolic_skew_mux
  import systolic_pkg::*;
#(
  parameter int SIZE     = 2,
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0] i_a_lat,
  input  logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0] i_b_lat,
  input  logic [beat_cnt_w(SIZE)-1:0]             i_beat,
  output logic [SIZE-1:0][IN_WIDTH-1:0]           o_a_vec,
  output logic [SIZE-1:0][IN_WIDTH-1:0]           o_b_vec
);

  localparam int BEAT_W = beat_cnt_w(SIZE);

  // Pick the element whose skewed position (lane + index) equals the beat.
  always_comb begin
    o_a_vec = '0;
    o_b_vec = '0;
    for (int lane = 0; lane < SIZE; lane++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (i_beat == BEAT_W'(lane + k)) begin
          o_a_vec[lane] = i_a_lat[lane][k];
          o_b_vec[lane] = i_b_lat[k][lane];
        end else begin
          o_a_vec[lane] = o_a_vec[lane];
          o_b_vec[lane] = o_b_vec[lane];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Transmit-side driver for the systolic matrix-multiply array: accepts two
// operand matrices, clears the array, streams skewed vectors, drains, and
// presents the result with a one-cycle done pulse.
// Optional build macro SYSTOLIC_FEEDER_RESULT_LATCH_EN: c_mat becomes a
// register captured from `out` on the edge entering DONE; otherwise c_mat
// passes `out` straight through.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE        = 2,
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int BEAT_CYCLES = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  output logic                                     ready,
  input  logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0]  a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0]  b_mat,
  output logic [SIZE-1:0][IN_WIDTH-1:0]            a_in,
  output logic [SIZE-1:0][IN_WIDTH-1:0]            b_in,
  output logic                                     load_en,
  output logic                                     mult_en,
  output logic                                     acc_en,
  output logic                                     clr_n,
  input  logic [SIZE-1:0][SIZE-1:0][OUT_WIDTH-1:0] out,
  output logic [SIZE-1:0][SIZE-1:0][OUT_WIDTH-1:0] c_mat,
  output logic                                     done,
  output logic                                     busy
);

  localparam int BEAT_W = beat_cnt_w(SIZE);
  localparam int HOLD_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] FEED_LAST  = BEAT_W'(2 * SIZE - 2);
  localparam logic [BEAT_W-1:0] DRAIN_LAST = BEAT_W'((SIZE > 1) ? SIZE - 2 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(BEAT_CYCLES - 1);

  feeder_state_t r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              w_beat_end;
  logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0] r_a, r_b;
  logic [SIZE-1:0][IN_WIDTH-1:0] w_a_sel, w_b_sel;
  logic w_ready_nxt, w_busy_nxt, w_done_nxt, w_en_nxt, w_clr_n_nxt, w_feed_nxt;

  // State, beat index and hold counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Operand capture on acceptance; later a_mat/b_mat changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_a <= a_mat;
      r_b <= b_mat;
    end else begin
      r_a <= r_a;
      r_b <= r_b;
    end
  end

  // Next-state and counter sequencing; a beat ends after BEAT_CYCLES cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_hold_nxt  = r_hold;
    w_beat_end  = (r_hold == HOLD_LAST);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CLEAR;
        end else begin
          w_state_nxt = IDLE;
        end
        w_beat_nxt = '0;
        w_hold_nxt = '0;
      end
      CLEAR: begin
        w_state_nxt = FEED;
        w_beat_nxt  = '0;
        w_hold_nxt  = '0;
      end
      FEED: begin
        if (w_beat_end) begin
          w_hold_nxt = '0;
          if (r_beat == FEED_LAST) begin
            w_beat_nxt  = '0;
            w_state_nxt = (SIZE > 1) ? DRAIN : DONE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      DRAIN: begin
        if (w_beat_end) begin
          w_hold_nxt = '0;
          if (r_beat == DRAIN_LAST) begin
            w_beat_nxt  = '0;
            w_state_nxt = DONE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_beat_nxt  = '0;
        w_hold_nxt  = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_beat_nxt  = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    w_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_done_nxt  = (w_state_nxt == DONE);
    w_en_nxt    = (w_state_nxt == FEED) || (w_state_nxt == DRAIN);
    w_clr_n_nxt = (w_state_nxt != CLEAR);
    w_feed_nxt  = (w_state_nxt == FEED);
  end

  systolic_skew_mux #(
    .SIZE     (SIZE),
    .IN_WIDTH (IN_WIDTH)
  ) u_skew (
    .i_a_lat (r_a),
    .i_b_lat (r_b),
    .i_beat  (w_beat_nxt),
    .o_a_vec (w_a_sel),
    .o_b_vec (w_b_sel)
  );

  // Registered control and stream outputs; streams are zero outside FEED.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      load_en <= 1'b0;
      mult_en <= 1'b0;
      acc_en  <= 1'b0;
      clr_n   <= 1'b1;
      a_in    <= '0;
      b_in    <= '0;
    end else begin
      ready   <= w_ready_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      load_en <= w_en_nxt;
      mult_en <= w_en_nxt;
      acc_en  <= w_en_nxt;
      clr_n   <= w_clr_n_nxt;
      a_in    <= w_feed_nxt ? w_a_sel : '0;
      b_in    <= w_feed_nxt ? w_b_sel : '0;
    end
  end

`ifdef SYSTOLIC_FEEDER_RESULT_LATCH_EN
  // Capture the array result on the edge entering DONE and hold it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_mat <= '0;
    end else if (w_state_nxt == DONE) begin
      c_mat <= out;
    end else begin
      c_mat <= c_mat;
    end
  end
`else
  assign c_mat = out;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder. Two feeder instances (3x3 single-cycle
// beats, 2x2 three-cycle beats) each drive a behavioural output-stationary
// systolic array whose accumulators feed back into the feeder's `out` port.
module tb_systolic_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance 3: SIZE=3, BEAT_CYCLES=1
  logic rst3, start3, ready3, load3, mult3, acc3, clr3, done3, busy3;
  logic [2:0][2:0][7:0]  a3, b3;
  logic [2:0][7:0]       ain3, bin3;
  logic [2:0][2:0][31:0] out3, c3;

  // Instance 2: SIZE=2, BEAT_CYCLES=3
  logic rst2, start2, ready2, load2, mult2, acc2, clr2, done2, busy2;
  logic [1:0][1:0][7:0]  a2, b2;
  logic [1:0][7:0]       ain2, bin2;
  logic [1:0][1:0][31:0] out2, c2;

  systolic_feeder #(.SIZE(3), .IN_WIDTH(8), .OUT_WIDTH(32), .BEAT_CYCLES(1)) u_feed3 (
    .clk(clk), .reset(rst3), .start(start3), .ready(ready3), .a_mat(a3), .b_mat(b3),
    .a_in(ain3), .b_in(bin3), .load_en(load3), .mult_en(mult3), .acc_en(acc3),
    .clr_n(clr3), .out(out3), .c_mat(c3), .done(done3), .busy(busy3));

  systolic_feeder #(.SIZE(2), .IN_WIDTH(8), .OUT_WIDTH(32), .BEAT_CYCLES(3)) u_feed2 (
    .clk(clk), .reset(rst2), .start(start2), .ready(ready2), .a_mat(a2), .b_mat(b2),
    .a_in(ain2), .b_in(bin2), .load_en(load2), .mult_en(mult2), .acc_en(acc2),
    .clr_n(clr2), .out(out2), .c_mat(c2), .done(done2), .busy(busy2));

  // Behavioural 3x3 array: a flows right, b flows down, acc += left * up.
  logic [7:0] ea3 [3][4];
  logic [7:0] eb3 [4][3];
  logic [7:0] ra3 [3][3];
  logic [7:0] rb3 [3][3];
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ea3[i][0] = ain3[i];
      eb3[0][i] = bin3[i];
      for (int j = 0; j < 3; j++) begin
        ea3[i][j+1] = ra3[i][j];
        eb3[i+1][j] = rb3[i][j];
      end
    end
  end
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!rst3 || !clr3) begin
          ra3[i][j]  <= 8'd0;
          rb3[i][j]  <= 8'd0;
          out3[i][j] <= 32'd0;
        end else if (mult3) begin
          ra3[i][j]  <= ea3[i][j];
          rb3[i][j]  <= eb3[i][j];
          out3[i][j] <= out3[i][j] + {24'd0, ea3[i][j]} * {24'd0, eb3[i][j]};
        end
      end
    end
  end

  // Behavioural 2x2 array stepping once per 3-cycle beat (on its last cycle).
  logic [7:0] ea2 [2][3];
  logic [7:0] eb2 [3][2];
  logic [7:0] ra2 [2][2];
  logic [7:0] rb2 [2][2];
  int ph2;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ea2[i][0] = ain2[i];
      eb2[0][i] = bin2[i];
      for (int j = 0; j < 2; j++) begin
        ea2[i][j+1] = ra2[i][j];
        eb2[i+1][j] = rb2[i][j];
      end
    end
  end
  always @(posedge clk) begin
    if (!rst2 || !mult2) ph2 <= 0;
    else                 ph2 <= (ph2 == 2) ? 0 : ph2 + 1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!rst2 || !clr2) begin
          ra2[i][j]  <= 8'd0;
          rb2[i][j]  <= 8'd0;
          out2[i][j] <= 32'd0;
        end else if (mult2 && ph2 == 2) begin
          ra2[i][j]  <= ea2[i][j];
          rb2[i][j]  <= eb2[i][j];
          out2[i][j] <= out2[i][j] + {24'd0, ea2[i][j]} * {24'd0, eb2[i][j]};
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst3 = 1'b0; rst2 = 1'b0; start3 = 1'b0; start2 = 1'b0;
    a3 = '0; b3 = '0; a2 = '0; b2 = '0;
    tick; tick;
    tests++;
    if (ready3 !== 1'b1 || busy3 !== 1'b0 || done3 !== 1'b0 || {load3, mult3, acc3} !== 3'b000 ||
        clr3 !== 1'b1 || ain3 !== '0 || bin3 !== '0 || c3 !== '0) begin
      fails++;
      $display("FAIL reset_s3: ready=%b busy=%b done=%b en=%b%b%b clr_n=%b a_in=%h b_in=%h c_mat=%h; want 1 0 0 000 1 zeros",
               ready3, busy3, done3, load3, mult3, acc3, clr3, ain3, bin3, c3);
    end
    tests++;
    if (ready2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0 || {load2, mult2, acc2} !== 3'b000 ||
        clr2 !== 1'b1 || ain2 !== '0 || bin2 !== '0 || c2 !== '0) begin
      fails++;
      $display("FAIL reset_s2: ready=%b busy=%b done=%b en=%b%b%b clr_n=%b a_in=%h b_in=%h c_mat=%h; want 1 0 0 000 1 zeros",
               ready2, busy2, done2, load2, mult2, acc2, clr2, ain2, bin2, c2);
    end
    rst3 = 1'b1; rst2 = 1'b1;
    tick;
  endtask

  task automatic test_product_3x3;
    int n;
    int exp3 [3][3] = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    a3 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    b3 = a3;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    n = 1;
    tests++;
    if (clr3 !== 1'b0 || mult3 !== 1'b0 || busy3 !== 1'b1 || ready3 !== 1'b0) begin
      fails++;
      $display("FAIL clear_cycle: clr_n=%b mult_en=%b busy=%b ready=%b; want 0 0 1 0", clr3, mult3, busy3, ready3);
    end
    while (done3 !== 1'b1 && n < 60) begin
      tick;
      n++;
      if (n == 2) begin
        tests++;
        if ({load3, mult3, acc3} !== 3'b111 || clr3 !== 1'b1 || ain3 !== {8'd0, 8'd0, 8'd1}) begin
          fails++;
          $display("FAIL feed_beat0: en=%b%b%b clr_n=%b a_in=%h; want 111 1 000001", load3, mult3, acc3, clr3, ain3);
        end
      end
      if (n == 3) begin
        tests++;
        if (ain3 !== {8'd0, 8'd4, 8'd2} || bin3 !== {8'd0, 8'd2, 8'd4}) begin
          fails++;
          $display("FAIL skew_beat1: a_in=%h b_in=%h; want 000402 000204", ain3, bin3);
        end
      end
      if (n == 4) begin
        tests++;
        if (ain3 !== {8'd7, 8'd5, 8'd3} || bin3 !== {8'd3, 8'd5, 8'd7}) begin
          fails++;
          $display("FAIL skew_beat2: a_in=%h b_in=%h; want 070503 030507", ain3, bin3);
        end
      end
    end
    tests++;
    if (n != 9) begin
      fails++;
      $display("FAIL latency_3x3: done at cycle %0d; want 9", n);
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        tests++;
        if (c3[i][j] !== 32'(exp3[i][j])) begin
          fails++;
          $display("FAIL c_mat_3x3[%0d][%0d]: got %0d want %0d", i, j, c3[i][j], exp3[i][j]);
        end
      end
    end
    tick;
    tests++;
    if (done3 !== 1'b0 || ready3 !== 1'b1 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b ready=%b busy=%b after DONE; want 0 1 0", done3, ready3, busy3);
    end
  endtask

  task automatic test_beat_hold;
    int n;
    logic [15:0] ea, eb;
    a2 = {8'd4, 8'd3, 8'd2, 8'd1};
    b2 = {8'd1, 8'd0, 8'd0, 8'd1};
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 80) begin
      tick;
      n++;
      if (n >= 2 && n <= 13) begin
        ea = (n <= 4) ? 16'h0001 : (n <= 7) ? 16'h0302 : (n <= 10) ? 16'h0400 : 16'h0000;
        eb = (n <= 4) ? 16'h0001 : (n <= 7) ? 16'h0000 : (n <= 10) ? 16'h0100 : 16'h0000;
        tests++;
        if (ain2 !== ea || bin2 !== eb || mult2 !== 1'b1) begin
          fails++;
          $display("FAIL hold_cycle%0d: a_in=%h b_in=%h mult_en=%b; want %h %h 1", n, ain2, bin2, mult2, ea, eb);
        end
      end
    end
    tests++;
    if (n != 14) begin
      fails++;
      $display("FAIL latency_beat3: done at cycle %0d; want 14", n);
    end
    tests++;
    if (c2 !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      fails++;
      $display("FAIL c_mat_beat3: got %h; want [[1,2],[3,4]]", c2);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int n;
    a2 = {8'd4, 8'd3, 8'd2, 8'd1};
    b2 = {8'd2, 8'd0, 8'd0, 8'd2};
    start2 = 1'b1;
    tick;
    a2 = {8'd1, 8'd1, 8'd1, 8'd1};
    b2 = {8'd4, 8'd3, 8'd2, 8'd1};
    n = 1;
    while (done2 !== 1'b1 && n < 80) begin
      tick;
      n++;
    end
    tests++;
    if (n != 14 || c2 !== {32'd8, 32'd6, 32'd4, 32'd2}) begin
      fails++;
      $display("FAIL b2b_job1: done cycle %0d c_mat=%h; want 14 [[2,4],[6,8]]", n, c2);
    end
    tick;
    tests++;
    if (ready2 !== 1'b1 || done2 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready: ready=%b done=%b in cycle after done; want 1 0", ready2, done2);
    end
    tick;
    start2 = 1'b0;
    tests++;
    if (busy2 !== 1'b1 || clr2 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b clr_n=%b; want 1 0", busy2, clr2);
    end
    n = 1;
    while (done2 !== 1'b1 && n < 80) begin
      tick;
      n++;
    end
    tests++;
    if (n != 14 || c2 !== {32'd6, 32'd4, 32'd6, 32'd4}) begin
      fails++;
      $display("FAIL b2b_job2: done cycle %0d c_mat=%h; want 14 [[4,6],[4,6]]", n, c2);
    end
    tick;
  endtask

  task automatic test_mid_reset;
    int n;
    logic saw_done;
    a2 = {8'd4, 8'd3, 8'd2, 8'd1};
    b2 = {8'd8, 8'd7, 8'd6, 8'd5};
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (n = 1; n < 5; n++) tick;
    rst2 = 1'b0;
    tick;
    tests++;
    if (ready2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0 || {load2, mult2, acc2} !== 3'b000 ||
        clr2 !== 1'b1 || ain2 !== '0 || bin2 !== '0 || c2 !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: ready=%b busy=%b done=%b en=%b%b%b clr_n=%b a_in=%h b_in=%h c_mat=%h",
               ready2, busy2, done2, load2, mult2, acc2, clr2, ain2, bin2, c2);
    end
    rst2 = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (done2 !== 1'b0 || busy2 !== 1'b0) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL midreset_no_done: activity after discarded job; want none");
    end
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 80) begin
      tick;
      n++;
    end
    tests++;
    if (n != 14 || c2 !== {32'd50, 32'd43, 32'd22, 32'd19}) begin
      fails++;
      $display("FAIL midreset_rerun: done cycle %0d c_mat=%h; want 14 [[19,22],[43,50]]", n, c2);
    end
    tick;
  endtask

  task automatic test_ignored_start;
    int n;
    logic relaunched;
    a3 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    b3 = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    n = 1;
    while (done3 !== 1'b1 && n < 60) begin
      tick;
      n++;
      if (n == 3) begin
        start3 = 1'b1;
        a3 = {9{8'd9}};
      end
      if (n == 4) start3 = 1'b0;
    end
    tests++;
    if (n != 9) begin
      fails++;
      $display("FAIL ignored_latency: done at cycle %0d; want 9", n);
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        tests++;
        if (c3[i][j] !== 32'(3 * i + j + 1)) begin
          fails++;
          $display("FAIL ignored_c_mat[%0d][%0d]: got %0d want %0d", i, j, c3[i][j], 3 * i + j + 1);
        end
      end
    end
    relaunched = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (busy3 !== 1'b0) relaunched = 1'b1;
    end
    tests++;
    if (relaunched) begin
      fails++;
      $display("FAIL ignored_no_relaunch: busy rose after job; want idle");
    end
  endtask

  initial begin
    test_reset();
    test_product_3x3();
    test_beat_hold();
    test_back_to_back();
    test_mid_reset();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
